// File: rtl/rv_mul_pkg.sv
`default_nettype none
// ============================================================================
// Package  : rv_mul_pkg
// Brief    : Operation encodings shared by the multiplier and the decoder.
// Revision : 1.0 - initial release
// ============================================================================
package rv_mul_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

    localparam logic [1:0] c_op_mul    = 2'b00;
    localparam logic [1:0] c_op_mulh   = 2'b01;
    localparam logic [1:0] c_op_mulhsu = 2'b10;
    localparam logic [1:0] c_op_mulhu  = 2'b11;

    function automatic logic op_a_signed(input logic [1:0] op);
        return op != c_op_mulhu;
    endfunction

    function automatic logic op_b_signed(input logic [1:0] op);
        return (op == c_op_mul) || (op == c_op_mulh);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv_mul_pp.sv
`default_nettype none
// ============================================================================
// Module   : rv_mul_pp
// Brief    : Four signed partial products of two (XLEN+1)-bit extended operands.
// Revision : 1.0 - initial release
// ============================================================================
module rv_mul_pp #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]          a_ext,
    input  logic [XLEN:0]          b_ext,
    output logic signed [XLEN+1:0] pp_ll,
    output logic signed [XLEN+1:0] pp_lh,
    output logic signed [XLEN+1:0] pp_hl,
    output logic signed [XLEN+1:0] pp_hh
);

    localparam int c_half = XLEN / 2;
    localparam int c_ppw  = XLEN + 2;

    // Low halves are unsigned magnitudes, high halves carry the operand sign.
    logic signed [c_ppw-1:0] w_a_lo;
    logic signed [c_ppw-1:0] w_a_hi;
    logic signed [c_ppw-1:0] w_b_lo;
    logic signed [c_ppw-1:0] w_b_hi;

    assign w_a_lo = $signed({{(c_ppw-c_half){1'b0}}, a_ext[c_half-1:0]});
    assign w_b_lo = $signed({{(c_ppw-c_half){1'b0}}, b_ext[c_half-1:0]});
    assign w_a_hi = $signed({{(c_half+1){a_ext[XLEN]}}, a_ext[XLEN:c_half]});
    assign w_b_hi = $signed({{(c_half+1){b_ext[XLEN]}}, b_ext[XLEN:c_half]});

    assign pp_ll = w_a_lo * w_b_lo;
    assign pp_lh = w_a_lo * w_b_hi;
    assign pp_hl = w_a_hi * w_b_lo;
    assign pp_hh = w_a_hi * w_b_hi;

endmodule
`default_nettype wire

// File: rtl/rv_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : rv_mul_pipe
// Brief    : Elastic STAGES-deep RISC-V M-extension multiplier with tag sideband.
// Revision : 1.0 - initial release
// ============================================================================
module rv_mul_pipe
    import rv_mul_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 6,
    parameter int TAG_W  = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [XLEN-1:0]  op_a_i,
    input  logic [XLEN-1:0]  op_b_i,
    input  logic [1:0]       op_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             flush_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             busy_o
);

    localparam int c_half = XLEN / 2;
    localparam int c_ppw  = XLEN + 2;
    localparam int c_sw   = 2 * XLEN;

    logic [STAGES:1] r_vld;
    logic [STAGES:1] w_vld_in;
    logic [STAGES:1] w_load;

    assign w_vld_in = {r_vld[STAGES-1:1], valid_i};

    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        // Stage k may load whenever any stage from k to the output is empty or the sink drains.
        assign w_load[k] = ready_i | ~(&r_vld[STAGES:k]);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_vld[k] <= 1'b0;
            end else if (flush_i) begin
                r_vld[k] <= 1'b0;
            end else if (w_load[k]) begin
                r_vld[k] <= w_vld_in[k];
            end
        end
    end

    assign ready_o = w_load[1];
    assign valid_o = r_vld[STAGES];
    assign busy_o  = |r_vld;

    // Stage 1: extended operands
    logic [XLEN:0]      w_a_ext;
    logic [XLEN:0]      w_b_ext;
    logic [XLEN:0]      r_a_ext;
    logic [XLEN:0]      r_b_ext;
    mul_op_e            r_op1;
    logic [TAG_W-1:0]   r_tag1;

    assign w_a_ext = {op_a_signed(op_i) & op_a_i[XLEN-1], op_a_i};
    assign w_b_ext = {op_b_signed(op_i) & op_b_i[XLEN-1], op_b_i};

    always_ff @(posedge clk_i) begin
        if (w_load[1]) begin
            r_a_ext <= w_a_ext;
            r_b_ext <= w_b_ext;
            r_op1   <= mul_op_e'(op_i);
            r_tag1  <= tag_i;
        end
    end

    // Stage 2: partial products
    logic signed [c_ppw-1:0] w_pp_ll, w_pp_lh, w_pp_hl, w_pp_hh;
    logic signed [c_ppw-1:0] r_pp_ll, r_pp_lh, r_pp_hl, r_pp_hh;
    mul_op_e                 r_op2;
    logic [TAG_W-1:0]        r_tag2;

    rv_mul_pp #(
        .XLEN (XLEN)
    ) u_pp (
        .a_ext (r_a_ext),
        .b_ext (r_b_ext),
        .pp_ll (w_pp_ll),
        .pp_lh (w_pp_lh),
        .pp_hl (w_pp_hl),
        .pp_hh (w_pp_hh)
    );

    always_ff @(posedge clk_i) begin
        if (w_load[2]) begin
            r_pp_ll <= w_pp_ll;
            r_pp_lh <= w_pp_lh;
            r_pp_hl <= w_pp_hl;
            r_pp_hh <= w_pp_hh;
            r_op2   <= r_op1;
            r_tag2  <= r_tag1;
        end
    end

    // Stage 3: recombine; bits above 2*XLEN are never selected so the sum stops there
    logic [c_sw-1:0] w_ll_x, w_lh_x, w_hl_x, w_hh_x, w_sum;
    logic [XLEN-1:0] w_sel;

    assign w_ll_x = {{(c_sw-c_ppw){r_pp_ll[c_ppw-1]}}, r_pp_ll};
    assign w_lh_x = {{(c_sw-c_ppw){r_pp_lh[c_ppw-1]}}, r_pp_lh};
    assign w_hl_x = {{(c_sw-c_ppw){r_pp_hl[c_ppw-1]}}, r_pp_hl};
    assign w_hh_x = {{(c_sw-c_ppw){r_pp_hh[c_ppw-1]}}, r_pp_hh};
    assign w_sum  = (w_hh_x << XLEN) + ((w_hl_x + w_lh_x) << c_half) + w_ll_x;
    assign w_sel  = (r_op2 == MUL) ? w_sum[XLEN-1:0] : w_sum[c_sw-1:XLEN];

    logic [XLEN-1:0]  r_res [3:STAGES];
    logic [TAG_W-1:0] r_tag [3:STAGES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_res[3] <= '0;
            r_tag[3] <= '0;
        end else if (w_load[3]) begin
            r_res[3] <= w_sel;
            r_tag[3] <= r_tag2;
        end
    end

    for (genvar k = 4; k <= STAGES; k++) begin : g_dly
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_res[k] <= '0;
                r_tag[k] <= '0;
            end else if (w_load[k]) begin
                r_res[k] <= r_res[k-1];
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    assign result_o = r_res[STAGES];
    assign tag_o    = r_tag[STAGES];

endmodule
`default_nettype wire

// File: tb/tb_rv_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_mul_pipe
// Brief    : Self-checking bench: reference-model scoreboard plus directed cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_mul_pipe;

    localparam int ST   = 6;
    localparam int ST64 = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0, ready_i = 1'b1, flush_i = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic [1:0]  op = '0;
    logic [4:0]  tag = '0;
    logic        ready_o, valid_o, busy_o;
    logic [31:0] res;
    logic [4:0]  tag_o;

    logic        v64 = 1'b0;
    logic [63:0] a64 = '0, b64 = '0;
    logic [1:0]  op64 = '0;
    logic        rdy64, vo64, busy64;
    logic [63:0] res64;
    logic [4:0]  tag64;

    always #5 clk = ~clk;

    rv_mul_pipe #(.XLEN(32), .STAGES(ST), .TAG_W(5)) dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .op_a_i(a), .op_b_i(b), .op_i(op), .tag_i(tag), .flush_i(flush_i),
        .valid_o(valid_o), .ready_i(ready_i), .result_o(res), .tag_o(tag_o),
        .busy_o(busy_o)
    );

    rv_mul_pipe #(.XLEN(64), .STAGES(ST64), .TAG_W(5)) dut64 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(v64), .ready_o(rdy64),
        .op_a_i(a64), .op_b_i(b64), .op_i(op64), .tag_i(5'd7), .flush_i(1'b0),
        .valid_o(vo64), .ready_i(1'b1), .result_o(res64), .tag_o(tag64),
        .busy_o(busy64)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: full signed product of the extended operands, then pick a half.
    function automatic logic [31:0] ref32(input logic [31:0] x, input logic [31:0] y,
                                          input logic [1:0] o);
        logic signed [65:0] xe, ye, p;
        xe = $signed({{34{(o != 2'b11) & x[31]}}, x});
        ye = $signed({{34{(o == 2'b00 || o == 2'b01) & y[31]}}, y});
        p  = xe * ye;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [63:0] ref64(input logic [63:0] x, input logic [63:0] y,
                                          input logic [1:0] o);
        logic signed [129:0] xe, ye, p;
        xe = $signed({{66{(o != 2'b11) & x[63]}}, x});
        ye = $signed({{66{(o == 2'b00 || o == 2'b01) & y[63]}}, y});
        p  = xe * ye;
        return (o == 2'b00) ? p[63:0] : p[127:64];
    endfunction

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          acc;
        bit          stalled;
        bit          has_lit;
        logic [31:0] lit;
    } ent_t;

    ent_t        q[$];
    bit          lit_en = 1'b0;
    logic [31:0] lit = '0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_res;
    logic [4:0]  prev_tag;

    // Scoreboard: check DUT state against the model, then apply this cycle's handshakes.
    always @(negedge clk) begin
        ent_t e;
        if (!rst_n) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            check("busy", busy_o, q.size() != 0);
            check("ready", ready_o, (q.size() < ST) || ready_i);
            if (valid_o) check("no_spurious_valid", q.size() != 0, 1'b1);
            if (prev_stall) begin
                check("hold_valid", valid_o, 1'b1);
                check("hold_result", res, prev_res);
                check("hold_tag", tag_o, prev_tag);
            end
            if (valid_o && ready_i && q.size() != 0) begin
                e = q.pop_front();
                check("result", res, e.res);
                check("tag", tag_o, e.tag);
                if (e.has_lit) check("result_literal", res, e.lit);
                if (!e.stalled) check("latency", cyc - e.acc, ST);
            end
            prev_stall = valid_o && !ready_i && !flush_i;
            prev_res   = res;
            prev_tag   = tag_o;
            if (!ready_i) foreach (q[i]) q[i].stalled = 1'b1;
            if (flush_i) begin
                q.delete();
            end else if (valid_i && ready_o) begin
                e.res = ref32(a, b, op);
                e.tag = tag;
                e.acc = cyc;
                e.stalled = !ready_i;
                e.has_lit = lit_en;
                e.lit = lit;
                q.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        valid_i = 1'b0;
        flush_i = 1'b0;
        ready_i = 1'b1;
        while (busy_o && n < 60) begin
            step();
            n++;
        end
        check("drain_timeout", busy_o, 1'b0);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] lits [4] = '{32'h80010002, 32'h3FFF7FFE, 32'hBFFF7FFF, 32'h40008001};
    logic [63:0] lits64 [3] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 64'h1};
    logic [1:0]  ops64 [3] = '{2'b11, 2'b01, 2'b00};

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_o", valid_o, 1'b0);
        check("rst_busy_o", busy_o, 1'b0);
        check("rst_result_o", res, 32'h0);
        check("rst_tag_o", tag_o, 5'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", ready_o, 1'b1);

        // Pin the reference model against hand-computed values
        for (int i = 0; i < 4; i++)
            check("model_pin32", ref32(32'h80000001, 32'h80010002, 2'(i)), lits[i]);
        for (int i = 0; i < 3; i++)
            check("model_pin64", ref64('1, '1, ops64[i]), lits64[i]);

        // Directed ops, back to back, tags 1..4
        for (int i = 0; i < 4; i++) begin
            step();
            valid_i = 1'b1;
            a = 32'h80000001;
            b = 32'h80010002;
            op = 2'(i);
            tag = 5'(i + 1);
            lit_en = 1'b1;
            lit = lits[i];
        end
        step();
        valid_i = 1'b0;
        lit_en = 1'b0;
        drain();

        // Stall the sink for 10 cycles while streaming
        step();
        ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            valid_i = 1'b1;
            a = rnd_operand();
            b = rnd_operand();
            op = 2'($urandom_range(0, 3));
            tag = 5'(i + 8);
            step();
        end
        check("stall_ready_low", ready_o, 1'b0);
        check("stall_busy", busy_o, 1'b1);
        drain();

        // Flush with three in flight and a new request
        for (int i = 0; i < 3; i++) begin
            step();
            valid_i = 1'b1;
            a = rnd_operand();
            b = rnd_operand();
            op = 2'($urandom_range(0, 3));
            tag = 5'(i + 20);
        end
        step();
        flush_i = 1'b1;
        tag = 5'd30;
        step();
        flush_i = 1'b0;
        valid_i = 1'b0;
        check("flush_busy", busy_o, 1'b0);
        check("flush_valid", valid_o, 1'b0);
        repeat (10) step();

        // Random traffic with back-pressure and occasional flush
        for (int i = 0; i < 400; i++) begin
            step();
            valid_i = ($urandom_range(0, 2) != 0);
            a = rnd_operand();
            b = rnd_operand();
            op = 2'($urandom_range(0, 3));
            tag = 5'($urandom);
            ready_i = ($urandom_range(0, 3) != 0);
            flush_i = ($urandom_range(0, 39) == 0);
        end
        drain();

        // Asynchronous reset two cycles after an accept
        step();
        valid_i = 1'b1;
        a = 32'h1234_5678;
        b = 32'h0000_0003;
        op = 2'b00;
        tag = 5'd9;
        step();
        valid_i = 1'b0;
        step();
        step();
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", valid_o, 1'b0);
        check("async_rst_busy", busy_o, 1'b0);
        check("async_rst_result", res, 32'h0);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("ready_after_async_rst", ready_o, 1'b1);
        repeat (12) step();

        // 64-bit instance, minimum depth
        for (int i = 0; i < 3; i++) begin
            int  acc;
            int  n;
            bit  found;
            step();
            v64 = 1'b1;
            a64 = '1;
            b64 = '1;
            op64 = ops64[i];
            @(negedge clk);
            acc = cyc;
            check("r64_ready", rdy64, 1'b1);
            step();
            v64 = 1'b0;
            n = 0;
            found = 1'b0;
            while (!found && n < 20) begin
                @(negedge clk);
                found = vo64;
                n++;
            end
            check("r64_seen", found, 1'b1);
            check("r64_latency", cyc - acc, ST64);
            check("r64_result", res64, lits64[i]);
            check("r64_tag", tag64, 5'd7);
        end

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv_mul_pipe.md
RV_MUL_PIPE -- requirements
Module: rv_mul_pipe

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, meaning operand/result width; legal values 32 or 64.
REQ-002 The module SHALL have parameter STAGES, default 6, meaning accept-to-result latency in cycles; legal range 3..8.
REQ-003 The module SHALL have parameter TAG_W, default 5, meaning the width of the sideband tag (destination register index).
REQ-004 clk_i  input  1  clock; the only clock, all state updates on its rising edge.
REQ-005 rst_ni  input  1  reset; asynchronous, active-low.
REQ-006 valid_i  input  1  upstream request valid.
REQ-007 ready_o  output  1  module can accept a request this cycle.
REQ-008 op_a_i  input  XLEN  operand A.
REQ-009 op_b_i  input  XLEN  operand B.
REQ-010 op_i  input  2  operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-011 tag_i  input  TAG_W  sideband tag, returned unchanged with the result.
REQ-012 flush_i  input  1  synchronous kill of all in-flight operations.
REQ-013 valid_o  output  1  result valid.
REQ-014 ready_i  input  1  downstream accepts result.
REQ-015 result_o  output  XLEN  selected product half.
REQ-016 tag_o  output  TAG_W  tag of the current result.
REQ-017 busy_o  output  1  high when any pipeline stage holds a valid entry.

Function
REQ-018 A request SHALL be accepted when valid_i && ready_o at a rising edge; a result SHALL be consumed when valid_o && ready_i.
REQ-019 Operand extension SHALL be: A sign-extended to XLEN+1 bits for MUL/MULH/MULHSU, zero-extended for MULHU; B sign-extended for MUL/MULH, zero-extended for MULHSU/MULHU.
REQ-020 The full signed product SHALL be 2*XLEN+2 bits; result_o SHALL be product[XLEN-1:0] for MUL, product[2*XLEN-1:XLEN] otherwise.
REQ-021 Stage 1 SHALL register the extended operands, op and tag; stage 2 SHALL register four half-width partial products; stage 3 SHALL register their shifted sum; stages 4..STAGES SHALL be delay registers; the output register is stage STAGES.
REQ-022 With no back-pressure, valid_o SHALL rise exactly STAGES cycles after the accepting edge, and one result per cycle SHALL be sustained.
REQ-023 Each stage k SHALL advance when stage k+1 is empty or stage k+1 advances (bubble collapse); the output stage advances when !valid_o || ready_i.
REQ-024 ready_o SHALL equal stage-1 empty or stage-1 advancing (combinational from ready_i through the advance chain).
REQ-025 While valid_o && !ready_i, result_o and tag_o SHALL hold stable; no entry SHALL be lost or duplicated.
REQ-026 Results SHALL leave in acceptance order.
REQ-027 flush_i SHALL clear every stage valid bit at the next edge, and a request presented in the same cycle as flush_i SHALL be dropped; the output register valid bit is also cleared.
REQ-028 Datapath registers SHALL load only when their stage advances; data in invalid stages is don't-care.

Reset
REQ-029 On rst_ni low, all stage valid bits SHALL clear immediately; valid_o=0, busy_o=0; ready_o SHALL be 1 once rst_ni deasserts.
REQ-030 result_o and tag_o SHALL reset to 0.
REQ-031 Reset mid-operation SHALL discard all in-flight entries; no result for them SHALL ever appear.

Structure
REQ-032 Package rv_mul_pkg SHALL hold the mul_op_e enum (MUL, MULH, MULHSU, MULHU) and the op encoding constants, shared with the decoder.
REQ-033 One sub-module rv_mul_pp SHALL generate the four partial products from the extended operands.
REQ-034 Per-stage valid/advance logic SHALL be a generate loop over STAGES.

Verification
REQ-035 XLEN=32, A=0x80000001, B=0x80010002, ready_i=1: MUL->0x80010002, MULH->0x3FFF7FFE, MULHSU->0xBFFF7FFF, MULHU->0x40008001, each exactly STAGES cycles after accept.
REQ-036 Four back-to-back requests, tags 1..4, ready_i=1 -> four consecutive valid_o cycles, tags 1,2,3,4 in order.
REQ-037 Hold ready_i=0 for 10 cycles while streaming -> ready_o drops after STAGES entries fill; on release, all results emerge in order, result_o stable while stalled.
REQ-038 Assert flush_i with 3 entries in flight and a new valid_i -> busy_o=0 next cycle, no valid_o for any of them.
REQ-039 Pull rst_ni low two cycles after accept -> valid_o=0, result_o=0 immediately; no late result.
REQ-040 XLEN=64, A=B=0xFFFFFFFFFFFFFFFF: MULHU->0xFFFFFFFFFFFFFFFE, MULH->0, MUL->1.
